// File: rtl/firebird_mc_cu_if.sv
// Control/memory handshake bundle for the Firebird multi-cycle control unit.
// The control unit takes the master view; datapath and memory take the slave view.
interface firebird_mc_cu_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       mem_iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       illegal_instr;
    logic       timeout;
    logic [2:0] state;

    modport master (
        input  opcode, mem_ready,
        output mem_req, mem_write, mem_iord, ir_write, pc_write, branch, jump,
               alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
               illegal_instr, timeout, state
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, mem_write, mem_iord, ir_write, pc_write, branch, jump,
               alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
               illegal_instr, timeout, state
    );
endinterface

// File: rtl/firebird_mc_cu.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/exec/mem/writeback per
// instruction, with sticky illegal-opcode and memory-timeout traps.
module firebird_mc_cu #(
    parameter int TIMEOUT_W   = 4,
    parameter bit ENABLE_JUMP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    firebird_mc_cu_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
    } class_t;

    // Last count value at which one more un-acked cycle means a trap.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(2 ** TIMEOUT_W - 2);

    function automatic class_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: classify = C_R;
            7'b0010011: classify = C_I;
            7'b0000011: classify = C_LOAD;
            7'b0100011: classify = C_STORE;
            7'b1100011: classify = C_BRANCH;
            7'b1101111: classify = ENABLE_JUMP ? C_JAL   : C_NONE;
            7'b1100111: classify = ENABLE_JUMP ? C_JALR  : C_NONE;
            7'b0110111: classify = ENABLE_JUMP ? C_LUI   : C_NONE;
            7'b0010111: classify = ENABLE_JUMP ? C_AUIPC : C_NONE;
            default:    classify = C_NONE;
        endcase
    endfunction

    state_t               r_state;
    class_t               r_class;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_illegal;
    logic                 r_timeout;

    state_t               w_next_state;
    class_t               w_class_dec;
    logic                 w_set_ill;
    logic                 w_set_to;
    logic                 w_cnt_hit;
    logic                 w_mem_phase;

    logic       w_mem_req, w_mem_write, w_mem_iord, w_ir_write, w_pc_write;
    logic       w_branch, w_jump, w_reg_write;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_alu_op, w_mem_to_reg;

    assign w_class_dec = classify(bus.opcode);
    assign w_cnt_hit   = (r_cnt == CNT_LAST);
    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_next_state = r_state;
        w_set_ill    = 1'b0;
        w_set_to     = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    w_next_state = S_DECODE;
                end else if (w_cnt_hit) begin
                    w_next_state = S_TRAP;
                    w_set_to     = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_class_dec == C_NONE) begin
                    w_next_state = S_TRAP;
                    w_set_ill    = 1'b1;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_class)
                    C_LOAD, C_STORE: w_next_state = S_MEM;
                    C_BRANCH:        w_next_state = S_FETCH;
                    default:         w_next_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    w_next_state = (r_class == C_LOAD) ? S_WB : S_FETCH;
                end else if (w_cnt_hit) begin
                    w_next_state = S_TRAP;
                    w_set_to     = 1'b1;
                end
            end
            S_WB:    w_next_state = S_FETCH;
            S_TRAP:  w_next_state = S_TRAP;
            default: w_next_state = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_class   <= C_NONE;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_class <= w_class_dec;
            end
            if (!w_mem_phase || bus.mem_ready || (w_next_state != r_state)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_set_ill) r_illegal <= 1'b1;
            if (w_set_to)  r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_iord   = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_mem_to_reg = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
            end
            S_EXEC: begin
                case (r_class)
                    C_R: w_alu_op = 2'b10;
                    C_I: begin
                        w_alu_src_b = 2'b01;
                        w_alu_op    = 2'b11;
                    end
                    C_LOAD, C_STORE: w_alu_src_b = 2'b01;
                    C_BRANCH: begin
                        w_alu_op = 2'b01;
                        w_branch = 1'b1;
                    end
                    C_JAL: begin
                        w_alu_src_a = 2'b01;
                        w_alu_src_b = 2'b01;
                        w_jump      = 1'b1;
                        w_pc_write  = 1'b1;
                    end
                    C_JALR: begin
                        w_alu_src_b = 2'b01;
                        w_jump      = 1'b1;
                        w_pc_write  = 1'b1;
                    end
                    C_LUI: begin
                        w_alu_src_a = 2'b10;
                        w_alu_src_b = 2'b01;
                    end
                    C_AUIPC: begin
                        w_alu_src_a = 2'b01;
                        w_alu_src_b = 2'b01;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                w_mem_iord  = 1'b1;
                w_mem_write = (r_class == C_STORE);
            end
            S_WB: begin
                w_reg_write = 1'b1;
                case (r_class)
                    C_LOAD:        w_mem_to_reg = 2'b01;
                    C_JAL, C_JALR: w_mem_to_reg = 2'b10;
                    default:       w_mem_to_reg = 2'b00;
                endcase
            end
            default: ;
        endcase
    end

    // Reset forces every output low combinationally, not just from the next edge.
    assign bus.mem_req       = rst_n & w_mem_req;
    assign bus.mem_write     = rst_n & w_mem_write;
    assign bus.mem_iord      = rst_n & w_mem_iord;
    assign bus.ir_write      = rst_n & w_ir_write;
    assign bus.pc_write      = rst_n & w_pc_write;
    assign bus.branch        = rst_n & w_branch;
    assign bus.jump          = rst_n & w_jump;
    assign bus.reg_write     = rst_n & w_reg_write;
    assign bus.alu_src_a     = rst_n ? w_alu_src_a  : 2'b00;
    assign bus.alu_src_b     = rst_n ? w_alu_src_b  : 2'b00;
    assign bus.alu_op        = rst_n ? w_alu_op     : 2'b00;
    assign bus.mem_to_reg    = rst_n ? w_mem_to_reg : 2'b00;
    assign bus.illegal_instr = rst_n & r_illegal;
    assign bus.timeout       = rst_n & r_timeout;
    assign bus.state         = rst_n ? r_state : 3'd0;

endmodule

// File: tb/tb_firebird_mc_cu.sv
// Directed bench for firebird_mc_cu: per-cycle expected output vectors for each
// instruction class, traps, timeout boundary and mid-instruction reset.
module tb_firebird_mc_cu;

    logic clk;
    logic rst_n;
    logic rst_n_b;
    int   n_checks;
    int   n_pass;

    firebird_mc_cu_if ifa ();
    firebird_mc_cu_if ifb ();

    firebird_mc_cu #(.TIMEOUT_W(4), .ENABLE_JUMP(1'b1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    firebird_mc_cu #(.TIMEOUT_W(4), .ENABLE_JUMP(1'b0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {state, req, wr, iord, irw, pcw, br, jmp, a, b, op, m2r, rw, ill, to}
    logic [20:0] obs_a;
    logic [20:0] obs_b;
    assign obs_a = {ifa.state, ifa.mem_req, ifa.mem_write, ifa.mem_iord, ifa.ir_write,
                    ifa.pc_write, ifa.branch, ifa.jump, ifa.alu_src_a, ifa.alu_src_b,
                    ifa.alu_op, ifa.mem_to_reg, ifa.reg_write, ifa.illegal_instr, ifa.timeout};
    assign obs_b = {ifb.state, ifb.mem_req, ifb.mem_write, ifb.mem_iord, ifb.ir_write,
                    ifb.pc_write, ifb.branch, ifb.jump, ifb.alu_src_a, ifb.alu_src_b,
                    ifb.alu_op, ifb.mem_to_reg, ifb.reg_write, ifb.illegal_instr, ifb.timeout};

    function automatic logic [20:0] ex(input logic [2:0] st, input logic [6:0] strb,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic [1:0] m2r,
                                       input logic [2:0] flg);
        return {st, strb, a, b, op, m2r, flg};
    endfunction

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    localparam logic [20:0] F_RDY    = ex(3'd0, 7'b1001100, 2'd1, 2'd2, 2'd0, 2'd0, 3'b000);
    localparam logic [20:0] F_WAIT   = ex(3'd0, 7'b1000000, 2'd1, 2'd2, 2'd0, 2'd0, 3'b000);
    localparam logic [20:0] DEC      = ex(3'd1, 7'b0000000, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000);
    localparam logic [20:0] X_R      = ex(3'd2, 7'b0000000, 2'd0, 2'd0, 2'd2, 2'd0, 3'b000);
    localparam logic [20:0] X_I      = ex(3'd2, 7'b0000000, 2'd0, 2'd1, 2'd3, 2'd0, 3'b000);
    localparam logic [20:0] X_LS     = ex(3'd2, 7'b0000000, 2'd0, 2'd1, 2'd0, 2'd0, 3'b000);
    localparam logic [20:0] X_BR     = ex(3'd2, 7'b0000010, 2'd0, 2'd0, 2'd1, 2'd0, 3'b000);
    localparam logic [20:0] X_JAL    = ex(3'd2, 7'b0000101, 2'd1, 2'd1, 2'd0, 2'd0, 3'b000);
    localparam logic [20:0] X_JALR   = ex(3'd2, 7'b0000101, 2'd0, 2'd1, 2'd0, 2'd0, 3'b000);
    localparam logic [20:0] X_LUI    = ex(3'd2, 7'b0000000, 2'd2, 2'd1, 2'd0, 2'd0, 3'b000);
    localparam logic [20:0] X_AUIPC  = ex(3'd2, 7'b0000000, 2'd1, 2'd1, 2'd0, 2'd0, 3'b000);
    localparam logic [20:0] M_LD     = ex(3'd3, 7'b1010000, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000);
    localparam logic [20:0] M_ST     = ex(3'd3, 7'b1110000, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000);
    localparam logic [20:0] WB_ALU   = ex(3'd4, 7'b0000000, 2'd0, 2'd0, 2'd0, 2'd0, 3'b100);
    localparam logic [20:0] WB_LD    = ex(3'd4, 7'b0000000, 2'd0, 2'd0, 2'd0, 2'd1, 3'b100);
    localparam logic [20:0] WB_PC    = ex(3'd4, 7'b0000000, 2'd0, 2'd0, 2'd0, 2'd2, 3'b100);
    localparam logic [20:0] TRAP_ILL = ex(3'd5, 7'b0000000, 2'd0, 2'd0, 2'd0, 2'd0, 3'b010);
    localparam logic [20:0] TRAP_TO  = ex(3'd5, 7'b0000000, 2'd0, 2'd0, 2'd0, 2'd0, 3'b001);

    task automatic test_reset();
        rst_n = 1'b0;
        rst_n_b = 1'b0;
        ifa.opcode = OP_R;
        ifa.mem_ready = 1'b1;
        ifb.opcode = OP_R;
        ifb.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (obs_a !== 21'd0) $display("FAIL reset_a[%0d]: got %h, expected %h", i, obs_a, 21'd0);
            else n_pass++;
            n_checks++;
            if (obs_b !== 21'd0) $display("FAIL reset_b[%0d]: got %h, expected %h", i, obs_b, 21'd0);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_r_type();
        logic [20:0] exp [4];
        exp = '{F_RDY, DEC, X_R, WB_ALU};
        for (int i = 0; i < 4; i++) begin
            ifa.opcode = OP_R;
            ifa.mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs_a !== exp[i]) $display("FAIL r_type[%0d]: got %h, expected %h", i, obs_a, exp[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        logic [20:0] exp [8];
        logic        rdy [8];
        exp = '{F_RDY, DEC, X_LS, M_LD, M_LD, M_LD, M_LD, WB_LD};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            ifa.opcode = OP_LOAD;
            ifa.mem_ready = rdy[i];
            #1;
            n_checks++;
            if (obs_a !== exp[i]) $display("FAIL load_wait[%0d]: got %h, expected %h", i, obs_a, exp[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_branch();
        logic [20:0] exp [7];
        logic [6:0]  ops [7];
        exp = '{F_RDY, DEC, X_LS, M_ST, F_RDY, DEC, X_BR};
        ops = '{OP_STORE, OP_STORE, OP_STORE, OP_STORE, OP_BR, OP_BR, OP_BR};
        for (int i = 0; i < 7; i++) begin
            ifa.opcode = ops[i];
            ifa.mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs_a !== exp[i]) $display("FAIL store_branch[%0d]: got %h, expected %h", i, obs_a, exp[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump_upper();
        logic [20:0] exp [12];
        logic [6:0]  ops [12];
        exp = '{F_RDY, DEC, X_JAL, WB_PC, F_RDY, DEC, X_JALR, WB_PC, F_RDY, DEC, X_LUI, WB_ALU};
        ops = '{OP_JAL, OP_JAL, OP_JAL, OP_JAL, OP_JALR, OP_JALR, OP_JALR, OP_JALR,
                OP_LUI, OP_LUI, OP_LUI, OP_LUI};
        for (int i = 0; i < 12; i++) begin
            ifa.opcode = ops[i];
            ifa.mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs_a !== exp[i]) $display("FAIL jump_upper[%0d]: got %h, expected %h", i, obs_a, exp[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] exp [9];
        logic [6:0]  ops [9];
        exp = '{F_RDY, DEC, X_I, WB_ALU, F_RDY, DEC, X_AUIPC, WB_ALU, F_WAIT};
        ops = '{OP_I, OP_I, OP_I, OP_I, OP_AUIPC, OP_AUIPC, OP_AUIPC, OP_AUIPC, OP_R};
        for (int i = 0; i < 9; i++) begin
            ifa.opcode = ops[i];
            ifa.mem_ready = (i != 8);
            #1;
            n_checks++;
            if (obs_a !== exp[i]) $display("FAIL back_to_back[%0d]: got %h, expected %h", i, obs_a, exp[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [20:0] exp [6];
        exp = '{F_RDY, DEC, TRAP_ILL, TRAP_ILL, TRAP_ILL, TRAP_ILL};
        for (int i = 0; i < 6; i++) begin
            ifa.opcode = OP_BAD;
            ifa.mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs_a !== exp[i]) $display("FAIL illegal[%0d]: got %h, expected %h", i, obs_a, exp[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_a !== 21'd0) $display("FAIL illegal_rst: got %h, expected %h", obs_a, 21'd0);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifa.opcode = OP_R;
        ifa.mem_ready = 1'b0;
        #1;
        n_checks++;
        if (obs_a !== F_WAIT) $display("FAIL illegal_clear: got %h, expected %h", obs_a, F_WAIT);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_nojump();
        logic [20:0] exp [5];
        exp = '{F_RDY, DEC, TRAP_ILL, TRAP_ILL, TRAP_ILL};
        rst_n_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifb.opcode = OP_JAL;
            ifb.mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs_b !== exp[i]) $display("FAIL nojump[%0d]: got %h, expected %h", i, obs_b, exp[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [20:0] e;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        // 15 un-acked FETCH cycles, then TRAP.
        for (int i = 0; i < 17; i++) begin
            ifa.opcode = OP_R;
            ifa.mem_ready = 1'b0;
            e = (i < 15) ? F_WAIT : TRAP_TO;
            #1;
            n_checks++;
            if (obs_a !== e) $display("FAIL timeout[%0d]: got %h, expected %h", i, obs_a, e);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Ack on the 15th cycle wins over the trap.
        for (int i = 0; i < 18; i++) begin
            ifa.opcode = OP_R;
            ifa.mem_ready = (i == 14);
            if (i < 14)       e = F_WAIT;
            else if (i == 14) e = F_RDY;
            else if (i == 15) e = DEC;
            else if (i == 16) e = X_R;
            else              e = WB_ALU;
            #1;
            n_checks++;
            if (obs_a !== e) $display("FAIL timeout_ack[%0d]: got %h, expected %h", i, obs_a, e);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [20:0] exp [4];
        logic [20:0] post [5];
        logic        rdy [5];
        exp  = '{F_RDY, DEC, X_LS, M_LD};
        post = '{F_WAIT, F_RDY, DEC, X_R, WB_ALU};
        rdy  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            ifa.opcode = OP_LOAD;
            ifa.mem_ready = (i < 3);
            #1;
            n_checks++;
            if (obs_a !== exp[i]) $display("FAIL reset_mid[%0d]: got %h, expected %h", i, obs_a, exp[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        ifa.mem_ready = 1'b1;
        #1;
        n_checks++;
        if (obs_a !== 21'd0) $display("FAIL reset_mid_zero: got %h, expected %h", obs_a, 21'd0);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifa.opcode = OP_R;
            ifa.mem_ready = rdy[i];
            #1;
            n_checks++;
            if (obs_a !== post[i]) $display("FAIL reset_mid_after[%0d]: got %h, expected %h", i, obs_a, post[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_r_type();
        test_load_wait();
        test_store_branch();
        test_jump_upper();
        test_back_to_back();
        test_illegal();
        test_illegal_nojump();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
